// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_stage_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    // Canonical RISC-V NOP (addi x0, x0, 0); used as the memory fill value.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // RUN: requests may issue. DRAIN: waiting for discarded responses to return.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Observation struct: FSM state and the three counters, zero-extended.
    typedef struct packed {
        fetch_state_e state;
        logic [7:0]   credits;
        logic [7:0]   outstanding;
        logic [7:0]   stale;
    } fetch_dbg_t;

    // Redirect targets are word aligned: the two low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, the redirect
// source and the downstream instruction queue.
//
// Handshake rule: a request transfers on a rising clk edge where both
// imem_req_valid and imem_req_ready are 1. Once valid is raised, the address
// stays unchanged until that transfer happens. The only exception is a
// redirect, which withdraws the request. Responses, redirects, queue pushes,
// pops and flushes are single-cycle pulses with no back-pressure.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            q_write;
    logic [INSTR_W-1:0] q_wrData;
    logic [XLEN-1:0] q_wr_pc;
    logic            q_read_fire;
    logic            q_flush;

    // Fetch stage side.
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output q_write,
        output q_wrData,
        output q_wr_pc,
        input  q_read_fire,
        output q_flush
    );

    // Environment side: memory, redirect source and queue.
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  q_write,
        input  q_wrData,
        input  q_wr_pc,
        output q_read_fire,
        input  q_flush
    );

endinterface

// File: rtl/fetch_stage_pc_tag_fifo.sv
// Small FIFO holding the PC of every in-flight request. Responses come back
// in order, so the head entry is always the PC of the next response.
module pc_tag_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            clear,
    output logic [XLEN-1:0] head_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Pointers wrap at DEPTH, so the depth does not have to be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy tracking; clear drops every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage has no reset; entries are only read after they are written.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_pc;
        end
    end

    assign head_pc = slots[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (push && !clear) |-> (count != CW'(DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (pop && !clear) |-> (count != '0));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end. It generates sequential PCs, requests words
// from instruction memory and pushes the returned words into the downstream
// queue. A credit counter mirrors the free slots in that queue, so a request
// only issues when its response is guaranteed a slot. A redirect flushes the
// queue. Responses that were already in flight at the redirect are counted
// as stale and are discarded when they return.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 8,
    parameter int              MAX_OUT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus,
    output fetch_dbg_t    dbg
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [OW-1:0]   out_q, out_d;
    logic [OW-1:0]   stale_q, stale_d;

    logic               q_write_q, q_write_d;
    logic [INSTR_W-1:0] q_wdata_q;
    logic [XLEN-1:0]    q_wpc_q;
    logic               q_flush_q;

    logic            req_valid;
    logic            fire;
    logic            rsp_stale;
    logic            rsp_live;
    logic            read_credit;
    logic [XLEN-1:0] head_pc;

    // Issue gating and per-cycle event decode. A redirect cycle never issues,
    // so the only in-flight requests at a redirect are already counted.
    always_comb begin
        req_valid   = rst && (state_q == RUN) && (credits_q != '0) &&
                      (out_q < OW'(MAX_OUT)) && !bus.redirect_valid;
        fire        = req_valid && bus.imem_req_ready;
        rsp_stale   = bus.imem_rsp_valid && (stale_q != '0);
        rsp_live    = bus.imem_rsp_valid && (stale_q == '0);
        // Pops reported during the flush cycle refer to entries that no
        // longer exist, so they must not return a credit.
        read_credit = bus.q_read_fire && !q_flush_q;
        q_write_d   = rsp_live && !bus.redirect_valid;
    end

    // Next-state logic for the FSM, PC and counters. A redirect overrides the
    // normal update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        out_d     = out_q + OW'(fire) - OW'(bus.imem_rsp_valid);
        stale_d   = stale_q - OW'(rsp_stale);
        credits_d = credits_q - CW'(fire) + CW'(read_credit) + CW'(rsp_stale);

        if (fire) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end

        if ((state_q == DRAIN) && (stale_d == '0)) begin
            state_d = RUN;
        end

        if (bus.redirect_valid) begin
            pc_d = align_pc(bus.redirect_pc);
            // Every request still in flight after this cycle is stale. Each
            // stale response keeps its credit until it returns. The flushed
            // queue frees all other slots.
            stale_d   = out_d;
            credits_d = CW'(QDEPTH) - CW'(out_d);
            state_d   = (out_d != '0) ? DRAIN : RUN;
        end
    end

    // FSM state, fetch PC and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            credits_q <= CW'(QDEPTH);
            out_q     <= '0;
            stale_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            credits_q <= credits_d;
            out_q     <= out_d;
            stale_q   <= stale_d;
        end
    end

    // Registered queue push and flush. The data and PC fields hold their
    // last value between pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_write_q <= 1'b0;
            q_wdata_q <= '0;
            q_wpc_q   <= '0;
            q_flush_q <= 1'b0;
        end else begin
            q_write_q <= q_write_d;
            q_flush_q <= bus.redirect_valid;
            if (q_write_d) begin
                q_wdata_q <= bus.imem_rsp_data;
                q_wpc_q   <= head_pc;
            end
        end
    end

    pc_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push    (fire),
        .push_pc (pc_q),
        .pop     (rsp_live && !bus.redirect_valid),
        .clear   (bus.redirect_valid),
        .head_pc (head_pc)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.q_write        = q_write_q;
    assign bus.q_wrData       = q_wdata_q;
    assign bus.q_wr_pc        = q_wpc_q;
    assign bus.q_flush        = q_flush_q;

    assign dbg = '{state:       state_q,
                   credits:     8'(credits_q),
                   outstanding: 8'(out_q),
                   stale:       8'(stale_q)};

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rsp_valid |-> (out_q != '0));

    a_credit_bounds: assert property (@(posedge clk) disable iff (!rst)
        (credits_q <= CW'(QDEPTH)) && !(fire && (credits_q == '0)));

    a_write_flush_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(q_write_q && q_flush_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A cycle table covers queue fill, the credit
// return path and request hold. Hand-written sequences cover redirects and
// reset during drain. A small in-order memory model answers requests after a
// programmable latency.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_stage_if bus ();
    fetch_dbg_t    dbg;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (8),
        .MAX_OUT  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dbg (dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int wr_count = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Memory model state: accepted addresses and the cycle each response is due.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // Values observed during the most recent step.
    logic        obs_rv;
    logic [31:0] obs_addr;
    logic        obs_wr;
    logic        obs_flush;
    logic [31:0] obs_wpc;
    logic [31:0] obs_wdata;
    fetch_dbg_t  obs_dbg;

    typedef struct {
        logic        rdy;
        logic        rd;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_wr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return NOP_INSTR ^ {a[23:0], 8'h00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rd, input logic erv,
                       input logic [31:0] eaddr, input logic ewr, input logic [31:0] epc);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.exp_rv = erv;
        v.exp_addr = eaddr; v.exp_wr = ewr; v.exp_pc = epc;
        vecs.push_back(v);
    endtask

    // One clock cycle, entered and left at a falling edge. It samples the
    // registered outputs and drives this cycle's inputs, including any due
    // memory response. It then samples the request and records an accepted
    // request in the memory model.
    task automatic step(input logic rdy, input logic rd, input logic rv, input logic [31:0] rpc);
        obs_wr    = bus.q_write;
        obs_wpc   = bus.q_wr_pc;
        obs_wdata = bus.q_wrData;
        obs_flush = bus.q_flush;
        obs_dbg   = dbg;
        if (obs_wr) wr_count++;
        bus.imem_req_ready = rdy;
        bus.q_read_fire    = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        obs_rv   = bus.imem_req_valid;
        obs_addr = bus.imem_req_addr;
        if (obs_rv && rdy) begin
            mem_addr_q.push_back(obs_addr);
            mem_due_q.push_back(cyc + lat);
        end
        @(negedge clk);
        cyc++;
    endtask

    int          found;
    int          drain_writes;
    logic [31:0] saved_addr;
    fetch_dbg_t  saved_dbg;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.q_read_fire    = 1'b0;

        // Cycle table. With ready=1 and 1-cycle latency, eight pushes fill
        // the queue. A single pop then allows exactly one more fetch. Finally
        // a request is held for five not-ready cycles.
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 32'(4 * k), (k >= 2), 32'(4 * (k - 2)));
        add(1, 0, 0, 0, 1, 32'h18);              // 8: credits exhausted
        add(1, 0, 0, 0, 1, 32'h1C);              // 9
        add(1, 0, 0, 0, 0, 0);                   // 10
        add(1, 0, 0, 0, 0, 0);                   // 11
        add(1, 1, 0, 0, 0, 0);                   // 12: one pop
        add(1, 0, 1, 32'h20, 0, 0);              // 13: single refill request
        add(1, 0, 0, 0, 0, 0);                   // 14: response arrives
        add(1, 0, 0, 0, 1, 32'h20);              // 15
        add(1, 0, 0, 0, 0, 0);                   // 16
        add(0, 1, 0, 0, 0, 0);                   // 17: pop, memory not ready
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 32'h24, 0, 0);          // 18-22: held request
        add(1, 0, 1, 32'h24, 0, 0);              // 23: accepted
        add(1, 0, 0, 0, 0, 0);                   // 24
        add(1, 1, 0, 0, 1, 32'h24);              // 25: pushed, another pop
        add(1, 0, 1, 32'h28, 0, 0);              // 26: pc advanced only once
        add(1, 0, 0, 0, 0, 0);                   // 27
        add(1, 0, 0, 0, 1, 32'h28);              // 28
        add(1, 0, 0, 0, 0, 0);                   // 29

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_q_write", bus.q_write, 0);
        check("rst_q_flush", bus.q_flush, 0);
        check("rst_q_wrData", bus.q_wrData, 0);
        check("rst_q_wr_pc", bus.q_wr_pc, 0);
        check("rst_credits", dbg.credits, 8);
        check("rst_state", dbg.state, RUN);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].rdy, vecs[i].rd, 1'b0, '0);
            check($sformatf("v%0d_req_valid", i), obs_rv, vecs[i].exp_rv);
            if (vecs[i].exp_rv) check($sformatf("v%0d_req_addr", i), obs_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_q_write", i), obs_wr, vecs[i].exp_wr);
            if (vecs[i].exp_wr) begin
                check($sformatf("v%0d_q_wr_pc", i), obs_wpc, vecs[i].exp_pc);
                check($sformatf("v%0d_q_wrData", i), obs_wdata, mem_word(vecs[i].exp_pc));
            end
            check($sformatf("v%0d_q_flush", i), obs_flush, 0);
            if (i == 11) begin
                check("fill_write_count", wr_count, 8);
                check("fill_credits", obs_dbg.credits, 0);
            end
        end
        check("table_write_count", wr_count, 11);

        // Two requests in flight, then a redirect to 0x1000.
        repeat (4) step(0, 1, 0, '0);
        lat = 6;
        step(1, 0, 0, '0);
        check("s4_credits_before", obs_dbg.credits, 4);
        check("s4_req0_valid", obs_rv, 1);
        check("s4_req0_addr", obs_addr, 32'h2C);
        step(1, 0, 0, '0);
        check("s4_req1_valid", obs_rv, 1);
        check("s4_req1_addr", obs_addr, 32'h30);
        lat = 1;
        step(1, 0, 1, 32'h1000);
        check("s4_redir_req_valid", obs_rv, 0);
        step(1, 0, 0, '0);
        check("s4_flush", obs_flush, 1);
        check("s4_flush_no_write", obs_wr, 0);
        check("s4_drain_state", obs_dbg.state, DRAIN);
        check("s4_drain_stale", obs_dbg.stale, 2);
        check("s4_drain_credits", obs_dbg.credits, 6);
        check("s4_drain_req_valid", obs_rv, 0);
        found = 0;
        drain_writes = 0;
        saved_addr = '0;
        saved_dbg = '0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step(1, 0, 0, '0);
            if (obs_wr) drain_writes++;
            if (obs_rv) begin
                found = 1;
                saved_addr = obs_addr;
                saved_dbg = obs_dbg;
            end
        end
        check("s4_resume_seen", found, 1);
        check("s4_stale_dropped", drain_writes, 0);
        check("s4_resume_addr", saved_addr, 32'h1000);
        check("s4_resume_credits", saved_dbg.credits, 8);
        check("s4_resume_state", saved_dbg.state, RUN);

        // Redirect in the cycle the 0x1000 response arrives; low pc bits dropped.
        step(1, 0, 1, 32'h2002);
        check("s5_redir_req_valid", obs_rv, 0);
        step(1, 0, 0, '0);
        check("s5_flush", obs_flush, 1);
        check("s5_flush_no_write", obs_wr, 0);
        check("s5_req_valid", obs_rv, 1);
        check("s5_req_addr", obs_addr, 32'h2000);
        step(0, 0, 0, '0);
        check("s5_dropped_rsp", obs_wr, 0);
        step(0, 0, 0, '0);
        check("s5_write", obs_wr, 1);
        check("s5_wr_pc", obs_wpc, 32'h2000);
        check("s5_wrData", obs_wdata, mem_word(32'h2000));
        check("s5_credits", obs_dbg.credits, 7);

        // Reset asserted during DRAIN, in the flush cycle.
        lat = 6;
        step(1, 0, 0, '0);
        check("s6_req_addr", obs_addr, 32'h2004);
        step(0, 0, 1, 32'h3000);
        check("s6_pre_flush", bus.q_flush, 1);
        check("s6_pre_state", dbg.state, DRAIN);
        #2;
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        #1;
        check("s6_rst_req_valid", bus.imem_req_valid, 0);
        check("s6_rst_q_flush", bus.q_flush, 0);
        check("s6_rst_q_write", bus.q_write, 0);
        check("s6_rst_q_wrData", bus.q_wrData, 0);
        check("s6_rst_q_wr_pc", bus.q_wr_pc, 0);
        check("s6_rst_state", dbg.state, RUN);
        check("s6_rst_credits", dbg.credits, 8);
        check("s6_rst_stale", dbg.stale, 0);
        check("s6_rst_outstanding", dbg.outstanding, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        lat = 1;
        step(1, 0, 0, '0);
        check("s6_first_req_valid", obs_rv, 1);
        check("s6_first_req_addr", obs_addr, 32'h0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        check("s6_first_write", obs_wr, 1);
        check("s6_first_wr_pc", obs_wpc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
